// File: rtl/hsv2rgb_if.sv
// HSV pixel in / RGB pixel out bundle for the hsv2rgb converter, including
// the video timing sideband that travels alongside each pixel.
interface hsv2rgb_if;
  logic [8:0] hsv_h;
  logic [8:0] hsv_s;
  logic [7:0] hsv_v;
  logic       hsv_vs;
  logic       hsv_hs;
  logic       hsv_de;
  logic       hsv_valid;

  logic [7:0] rgb_r;
  logic [7:0] rgb_g;
  logic [7:0] rgb_b;
  logic       rgb_vs;
  logic       rgb_hs;
  logic       rgb_de;
  logic       rgb_valid;

  modport master (
    output hsv_h, hsv_s, hsv_v, hsv_vs, hsv_hs, hsv_de, hsv_valid,
    input  rgb_r, rgb_g, rgb_b, rgb_vs, rgb_hs, rgb_de, rgb_valid
  );

  modport slave (
    input  hsv_h, hsv_s, hsv_v, hsv_vs, hsv_hs, hsv_de, hsv_valid,
    output rgb_r, rgb_g, rgb_b, rgb_vs, rgb_hs, rgb_de, rgb_valid
  );
endinterface

// File: rtl/hsv2rgb.sv
// Four-stage free-running HSV-to-RGB converter; the timing sideband is
// delayed through a matching 4-deep shift register so it stays pixel-aligned.
module hsv2rgb (
  input logic      clk,
  input logic      reset,
  hsv2rgb_if.slave bus
);
  typedef enum logic [2:0] {SEC0, SEC1, SEC2, SEC3, SEC4, SEC5} sector_e;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
    logic valid;
  } side_t;

  // Stage 1: clamp, sector, offset within sector
  logic [8:0] h_clamp, s_clamp, sec_base;
  sector_e    i1_d, i1_q;
  logic [5:0] f1_d, f1_q;
  logic [8:0] s1_q;
  logic [7:0] v1_q;

  // Stage 2: chroma
  logic [16:0] vs_prod;
  logic [7:0]  c2_d, c2_q, v2_q;
  sector_e     i2_q;
  logic [5:0]  f2_q;

  // Stage 3: min channel and the rising/falling ramps
  logic [13:0] cf_prod;
  logic [7:0]  m3_d, xu3_d, xd3_d;
  logic [7:0]  m3_q, xu3_q, xd3_q, v3_q;
  sector_e     i3_q;

  // Stage 4: channel select
  logic [7:0] r4_d, g4_d, b4_d;
  logic [7:0] r4_q, g4_q, b4_q;

  side_t [3:0] side_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_clamp  = (bus.hsv_h >= 9'd360) ? 9'd0 : bus.hsv_h;
    s_clamp  = (bus.hsv_s > 9'd256) ? 9'd256 : bus.hsv_s;
    i1_d     = SEC0;
    sec_base = 9'd0;
    if (h_clamp >= 9'd300) begin
      i1_d = SEC5; sec_base = 9'd300;
    end else if (h_clamp >= 9'd240) begin
      i1_d = SEC4; sec_base = 9'd240;
    end else if (h_clamp >= 9'd180) begin
      i1_d = SEC3; sec_base = 9'd180;
    end else if (h_clamp >= 9'd120) begin
      i1_d = SEC2; sec_base = 9'd120;
    end else if (h_clamp >= 9'd60) begin
      i1_d = SEC1; sec_base = 9'd60;
    end
    f1_d = 6'(h_clamp - sec_base);
  end

  assign vs_prod = 17'(v1_q) * 17'(s1_q);
  assign c2_d    = 8'(vs_prod >> 8);

  assign cf_prod = 14'(c2_q) * 14'(f2_q);
  assign xu3_d   = 8'(cf_prod / 14'd60);
  assign xd3_d   = c2_q - xu3_d;
  assign m3_d    = v2_q - c2_q;

  // m + Xu and m + Xd are bounded by v, so 8-bit sums cannot wrap.
  always_comb begin
    r4_d = m3_q;
    g4_d = m3_q;
    b4_d = m3_q;
    unique case (i3_q)
      SEC0: begin r4_d = v3_q;          g4_d = m3_q + xu3_q; end
      SEC1: begin r4_d = m3_q + xd3_q;  g4_d = v3_q;         end
      SEC2: begin g4_d = v3_q;          b4_d = m3_q + xu3_q; end
      SEC3: begin g4_d = m3_q + xd3_q;  b4_d = v3_q;         end
      SEC4: begin r4_d = m3_q + xu3_q;  b4_d = v3_q;         end
      default: begin r4_d = v3_q;       b4_d = m3_q + xd3_q; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1_q  <= SEC0;
      f1_q  <= '0;
      s1_q  <= '0;
      v1_q  <= '0;
      c2_q  <= '0;
      v2_q  <= '0;
      i2_q  <= SEC0;
      f2_q  <= '0;
      m3_q  <= '0;
      xu3_q <= '0;
      xd3_q <= '0;
      v3_q  <= '0;
      i3_q  <= SEC0;
      r4_q  <= '0;
      g4_q  <= '0;
      b4_q  <= '0;
      // NOTE: the sideband shift register is reset too; a stale valid must never escape after reset.
      side_q <= '0;
    end else begin
      i1_q  <= i1_d;
      f1_q  <= f1_d;
      s1_q  <= s_clamp;
      v1_q  <= bus.hsv_v;
      c2_q  <= c2_d;
      v2_q  <= v1_q;
      i2_q  <= i1_q;
      f2_q  <= f1_q;
      m3_q  <= m3_d;
      xu3_q <= xu3_d;
      xd3_q <= xd3_d;
      v3_q  <= v2_q;
      i3_q  <= i2_q;
      r4_q  <= r4_d;
      g4_q  <= g4_d;
      b4_q  <= b4_d;
      side_q <= {side_q[2:0], side_t'({bus.hsv_vs, bus.hsv_hs, bus.hsv_de, bus.hsv_valid})};
    end
  end

  assign bus.rgb_r     = r4_q;
  assign bus.rgb_g     = g4_q;
  assign bus.rgb_b     = b4_q;
  assign bus.rgb_vs    = side_q[3].vs;
  assign bus.rgb_hs    = side_q[3].hs;
  assign bus.rgb_de    = side_q[3].de;
  assign bus.rgb_valid = side_q[3].valid;
endmodule

// File: doc/hsv2rgb.md
# hsv2rgb

Pipelined HSV-to-RGB converter: the inverse of the RGB-to-HSV stage in the video path. It takes one HSV pixel per clock, in the same encoding the forward stage produces, and returns 8-bit RGB. It also delays the video timing sideband (vs/hs/de/pixel valid) by the same fixed latency, so the block can sit in front of the display/VGA output after any HSV-domain processing.

## Interface
- No parameters; all widths are fixed by the HSV encoding (H 0..359 degrees, S 0..256 = 0..1.0, V 0..255).
- clk  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline state
- hsv_h  in  9  hue in degrees; values ≥360 are treated as 0
- hsv_s  in  9  saturation scaled by 256; values >256 are clamped to 256
- hsv_v  in  8  value (max channel)
- hsv_vs / hsv_hs / hsv_de / hsv_valid  in  1 each  timing sideband aligned with the HSV data
- rgb_r / rgb_g / rgb_b  out  8 each  converted pixel
- rgb_vs / rgb_hs / rgb_de / rgb_valid  out  1 each  sideband delayed to align with the RGB outputs

## Operation
- The pipeline is free-running: one pixel accepted every cycle, with no stall and no backpressure. The data path ignores valid; valid is only delayed alongside the data.
- **Stage 1:** clamp the inputs (h≥360 becomes 0; s>256 becomes 256).
  - Sector i = floor(h/60), range 0..5. Implement it as a compare chain against 60/120/180/240/300, not a divider.
  - f = h − 60·i, range 0..59.
  - Register i, f, s, v.
- **Stage 2:** chroma C = (v·s)>>8, 8 bits; s=256 gives C=v.
  - Register C, v, i, f.
- **Stage 3:**
  - m = v − C.
  - Xu = floor(C·f/60), range 0..C.
  - Xd = C − Xu. Xd is defined this way, not as floor(C·(60−f)/60).
  - Register m, v, Xu, Xd, i.
- **Stage 4:** select the output by sector and register (r,g,b):
  - i=0: (v, m+Xu, m)
  - i=1: (m+Xd, v, m)
  - i=2: (m, v, m+Xu)
  - i=3: (m, m+Xd, v)
  - i=4: (m+Xu, m, v)
  - i=5: (v, m, m+Xd)
- **Width rules:**
  - v·s is 17 bits before the shift.
  - C·f is 14 bits before the divide.
  - m+Xu and m+Xd never exceed v, so the sums are 8 bits with no saturation needed.
- **Round-trip requirement:** for any RGB input, forward conversion followed by this block returns each channel within ±2 of the original. Pure primaries, secondaries and greys must round-trip exactly.

## Timing
- Latency is 4 clocks: an input presented at edge N appears on rgb_* after edge N+4.
- The sideband uses a 4-deep shift register per signal, and it must stay aligned to the data exactly.
- **Reset:**
  - Asynchronous assertion immediately forces all outputs (rgb_r/g/b, rgb_vs/hs/de/valid) and all internal stages to 0.
  - Reset mid-frame discards in-flight pixels; no partial pixel is emitted.
  - After deassertion, outputs show the zero-filled pipeline for 4 cycles, then live data. rgb_valid stays 0 until a valid input has propagated through.
- Back-to-back pixels with different sectors each cycle must not interfere; there is no shared state between pixels.
- **Boundary conditions:**
  - s=0 gives (v,v,v).
  - v=0 gives (0,0,0) for any h and s.
  - h=359 gives sector 5 with f=59.

## Test plan
- h=0, s=256, v=255 → (255,0,0). h=120 → (0,255,0). h=240 → (0,0,255). h=60 → (255,255,0). Each appears exactly 4 cycles after input.
- h=30, s=128, v=200 → C=100, m=100, Xu=50 → (200,150,100). h=330, s=128, v=200 → i=5, f=30, Xd=50 → (200,100,150).
- s=0, v=77 at h = 0, 180 and 359 → (77,77,77) each. v=0, s=256, h=200 → (0,0,0).
- Out-of-range inputs: h=400, s=256, v=255 → (255,0,0). h=60, s=300, v=100 → same result as s=256: (100,100,0).
- Stream 1000 random RGB pixels through the forward stage and then this block, with random vs/hs/de/valid:
  - every channel matches within ±2;
  - the sideband on the output matches the input sideband delayed by 3+4 cycles.
- Assert reset for 1 cycle in the middle of the stream:
  - all outputs go to 0 asynchronously;
  - the next 4 output cycles are 0 with rgb_valid=0;
  - the first post-reset pixel then appears correctly.
